// File: rtl/sq_pkg.sv
// -----------------------------------------------------------------------------
// sq_pkg : shared types and constants for the store queue.
//   sq_entry_t     : one store-queue entry (address, data, tags, ROB index)
//   sq_ptr_t       : head/cmt/tail pointer for the default depth (MSB = wrap)
//   sq_tag_match() : single-bus CDB tag comparison
// PRF_IDX_W / ROB_IDX_W follow the machine-wide PRF_SIZE / ROB_SIZE macros.
// -----------------------------------------------------------------------------
`ifndef PRF_SIZE
`define PRF_SIZE 64
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif

package sq_pkg;

   localparam int SQ_ADDR_W    = 64;
   localparam int SQ_DATA_W    = 64;
   localparam int SQ_OFF_W     = 16;
   localparam int SQ_DEPTH_DEF = 8;
   localparam int PRF_IDX_W    = $clog2(`PRF_SIZE);
   localparam int ROB_IDX_W    = $clog2(`ROB_SIZE) + 1;
   localparam int SQ_PTR_W     = $clog2(SQ_DEPTH_DEF) + 1;

   typedef logic [SQ_PTR_W-1:0] sq_ptr_t;

   // data holds the producer tag in its low bits until data_valid is set.
   typedef struct packed {
      logic [SQ_ADDR_W-1:0] addr;
      logic                 addr_valid;
      logic [PRF_IDX_W-1:0] base_tag;
      logic [SQ_OFF_W-1:0]  offset;
      logic [SQ_DATA_W-1:0] data;
      logic                 data_valid;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic                 committed;
   } sq_entry_t;

   function automatic logic sq_tag_match(input logic                 cdb_valid,
                                         input logic [PRF_IDX_W-1:0] cdb_tag,
                                         input logic [PRF_IDX_W-1:0] tag);
      return cdb_valid && (cdb_tag == tag);
   endfunction

endpackage

// File: rtl/sq_slot.sv
// -----------------------------------------------------------------------------
// sq_slot : one store-queue entry with its CDB capture and address adder.
//   i_alloc       : write a dispatched store into this entry this cycle
//   i_base..      : dispatch operands (value, or tag in low bits when invalid)
//   i_capture_en  : entry is live and may snoop the CDBs this cycle
//   i_commit      : ROB committed this entry this cycle
//   i_free        : entry drained to the D-cache this cycle
//   i_cdb_*       : result buses, lowest index has priority
//   o_ready/o_*   : entry contents presented to the drain logic
// -----------------------------------------------------------------------------
module sq_slot
   import sq_pkg::*;
#(
   parameter int CDB_NUM = 2
) (
   input  logic                                clock,
   input  logic                                reset_n,
   input  logic                                i_alloc,
   input  logic [SQ_ADDR_W-1:0]                i_base,
   input  logic                                i_base_valid,
   input  logic [SQ_OFF_W-1:0]                 i_offset,
   input  logic [SQ_DATA_W-1:0]                i_data,
   input  logic                                i_data_valid,
   input  logic [ROB_IDX_W-1:0]                i_rob_idx,
   input  logic                                i_capture_en,
   input  logic                                i_commit,
   input  logic                                i_free,
   input  logic [CDB_NUM-1:0]                  i_cdb_valid,
   input  logic [CDB_NUM-1:0][PRF_IDX_W-1:0]   i_cdb_tag,
   input  logic [CDB_NUM-1:0][SQ_DATA_W-1:0]   i_cdb_data,
   output logic                                o_ready,
   output logic [SQ_ADDR_W-1:0]                o_addr,
   output logic [SQ_DATA_W-1:0]                o_data,
   output logic [ROB_IDX_W-1:0]                o_rob_idx,
   output logic                                o_committed
);

   sq_entry_t            r_entry;

   logic                 w_base_v;
   logic [PRF_IDX_W-1:0] w_base_tag;
   logic [SQ_OFF_W-1:0]  w_offset;
   logic                 w_data_v;
   logic [PRF_IDX_W-1:0] w_data_tag;
   logic                 w_snoop;
   logic                 w_base_hit;
   logic [SQ_DATA_W-1:0] w_base_cdb;
   logic                 w_data_hit;
   logic [SQ_DATA_W-1:0] w_data_cdb;
   logic [SQ_ADDR_W-1:0] w_addr_sum;

   // Operands come from the dispatch port on allocation (so same-cycle CDBs
   // bypass into the new entry) and from the stored entry otherwise.
   always_comb begin
      // NOTE: every signal gets a default before any condition so no path can leave it unassigned and infer a latch.
      w_base_v   = i_alloc ? i_base_valid : r_entry.addr_valid;
      w_base_tag = i_alloc ? i_base[PRF_IDX_W-1:0] : r_entry.base_tag;
      w_offset   = i_alloc ? i_offset : r_entry.offset;
      w_data_v   = i_alloc ? i_data_valid : r_entry.data_valid;
      w_data_tag = i_alloc ? i_data[PRF_IDX_W-1:0] : r_entry.data[PRF_IDX_W-1:0];
      w_snoop    = i_alloc | i_capture_en;
      w_base_hit = 1'b0;
      w_base_cdb = '0;
      w_data_hit = 1'b0;
      w_data_cdb = '0;
      // Walk from the highest bus down so the lowest matching index is last.
      for (int c = CDB_NUM - 1; c >= 0; c--) begin
         if (w_snoop && !w_base_v && sq_tag_match(i_cdb_valid[c], i_cdb_tag[c], w_base_tag)) begin
            w_base_hit = 1'b1;
            w_base_cdb = i_cdb_data[c];
         end
         if (w_snoop && !w_data_v && sq_tag_match(i_cdb_valid[c], i_cdb_tag[c], w_data_tag)) begin
            w_data_hit = 1'b1;
            w_data_cdb = i_cdb_data[c];
         end
      end
      w_addr_sum = (w_base_hit ? w_base_cdb : i_base)
                 + {{(SQ_ADDR_W-SQ_OFF_W){w_offset[SQ_OFF_W-1]}}, w_offset};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the entry is flop-based and its valid/committed bits must read 0 out of reset, so the whole struct is reset rather than left as uninitialised storage.
         r_entry <= '0;
      end else if (i_alloc) begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         r_entry.addr       <= (i_base_valid || w_base_hit) ? w_addr_sum : '0;
         r_entry.addr_valid <= i_base_valid | w_base_hit;
         r_entry.base_tag   <= i_base[PRF_IDX_W-1:0];
         r_entry.offset     <= i_offset;
         r_entry.data       <= w_data_hit ? w_data_cdb : i_data;
         r_entry.data_valid <= i_data_valid | w_data_hit;
         r_entry.rob_idx    <= i_rob_idx;
         r_entry.committed  <= 1'b0;
      end else begin
         if (w_base_hit) begin
            r_entry.addr       <= w_addr_sum;
            r_entry.addr_valid <= 1'b1;
         end
         if (w_data_hit) begin
            r_entry.data       <= w_data_cdb;
            r_entry.data_valid <= 1'b1;
         end
         if (i_commit) begin
            r_entry.committed <= 1'b1;
         end else if (i_free) begin
            r_entry.committed <= 1'b0;
         end
      end
   end

   assign o_ready     = r_entry.addr_valid & r_entry.data_valid;
   assign o_addr      = r_entry.addr;
   assign o_data      = r_entry.data;
   assign o_rob_idx   = r_entry.rob_idx;
   assign o_committed = r_entry.committed;

endmodule

// File: rtl/store_queue.sv
// -----------------------------------------------------------------------------
// store_queue : circular, program-ordered store queue.
//   disp_*        : 2-wide store dispatch, slot 0 older, compacted at tail
//   cdb_*         : CDB_NUM result buses snooped for base/data tags
//   commit_cnt    : 0..2 stores committed by the ROB this cycle
//   flush         : squash every uncommitted entry (tail <- updated cmt)
//   mem_req/ack   : one committed, ready head store per cycle to the D-cache
//   mem_addr/data/rob_idx : head entry contents, stable while mem_req is high
//   sq_free_cnt / sq_full / sq_empty : occupancy status
// Pointers head <= cmt <= tail carry an extra wrap bit so full and empty are
// distinguishable; index bits select the slot.
// -----------------------------------------------------------------------------
module store_queue
   import sq_pkg::*;
#(
   parameter int SQ_DEPTH  = 8,
   parameter int CDB_NUM   = 2,
   parameter int PRF_IDX_W = sq_pkg::PRF_IDX_W,
   parameter int ROB_IDX_W = sq_pkg::ROB_IDX_W
) (
   input  logic                                clock,
   input  logic                                reset_n,
   input  logic [1:0]                          disp_valid,
   input  logic [1:0][SQ_ADDR_W-1:0]           disp_base,
   input  logic [1:0]                          disp_base_valid,
   input  logic [1:0][SQ_OFF_W-1:0]            disp_offset,
   input  logic [1:0][SQ_DATA_W-1:0]           disp_data,
   input  logic [1:0]                          disp_data_valid,
   input  logic [1:0][ROB_IDX_W-1:0]           disp_rob_idx,
   input  logic [CDB_NUM-1:0]                  cdb_valid,
   input  logic [CDB_NUM-1:0][PRF_IDX_W-1:0]   cdb_tag,
   input  logic [CDB_NUM-1:0][SQ_DATA_W-1:0]   cdb_data,
   input  logic [1:0]                          commit_cnt,
   input  logic                                flush,
   input  logic                                mem_ack,
   output logic                                mem_req,
   output logic [SQ_ADDR_W-1:0]                mem_addr,
   output logic [SQ_DATA_W-1:0]                mem_data,
   output logic [ROB_IDX_W-1:0]                mem_rob_idx,
   output logic [$clog2(SQ_DEPTH):0]           sq_free_cnt,
   output logic                                sq_full,
   output logic                                sq_empty
);

   localparam int IDX_W = $clog2(SQ_DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PTR_W-1:0]     r_head;
   logic [PTR_W-1:0]     r_cmt;
   logic [PTR_W-1:0]     r_tail;

   logic [PTR_W-1:0]     w_in_use;
   logic [IDX_W-1:0]     w_head_idx;
   logic [IDX_W-1:0]     w_tail_idx;
   logic [IDX_W-1:0]     w_cmt_idx;
   logic [IDX_W-1:0]     w_slot1_idx;
   logic [1:0]           w_n_disp;
   logic                 w_ack;
   logic [PTR_W-1:0]     w_head_nxt;
   logic [PTR_W-1:0]     w_cmt_nxt;
   logic [PTR_W-1:0]     w_tail_nxt;

   logic                 w_slot_ready     [SQ_DEPTH];
   logic [SQ_ADDR_W-1:0] w_slot_addr      [SQ_DEPTH];
   logic [SQ_DATA_W-1:0] w_slot_data      [SQ_DEPTH];
   logic [ROB_IDX_W-1:0] w_slot_rob       [SQ_DEPTH];
   logic                 w_slot_committed [SQ_DEPTH];

   assign w_in_use    = r_tail - r_head;
   assign w_head_idx  = r_head[IDX_W-1:0];
   assign w_tail_idx  = r_tail[IDX_W-1:0];
   assign w_cmt_idx   = r_cmt[IDX_W-1:0];
   // Slot 1 lands right behind slot 0, or at tail itself when slot 0 is idle.
   assign w_slot1_idx = w_tail_idx + {{(IDX_W-1){1'b0}}, disp_valid[0]};
   assign w_n_disp    = {1'b0, disp_valid[0]} + {1'b0, disp_valid[1]};

   assign mem_req     = (r_head != r_cmt) & w_slot_ready[w_head_idx]
                      & w_slot_committed[w_head_idx];
   assign mem_addr    = w_slot_addr[w_head_idx];
   assign mem_data    = w_slot_data[w_head_idx];
   assign mem_rob_idx = w_slot_rob[w_head_idx];

   assign w_ack       = mem_req & mem_ack;
   assign w_head_nxt  = r_head + {{(PTR_W-1){1'b0}}, w_ack};
   assign w_cmt_nxt   = r_cmt + {{(PTR_W-2){1'b0}}, commit_cnt};
   // Flush rewinds tail onto the post-commit cmt, so same-cycle commits survive
   // and same-cycle dispatch is discarded.
   assign w_tail_nxt  = flush ? w_cmt_nxt : (r_tail + {{(PTR_W-2){1'b0}}, w_n_disp});

   assign sq_free_cnt = PTR_W'(SQ_DEPTH) - w_in_use;
   assign sq_full     = sq_free_cnt < PTR_W'(2);
   assign sq_empty    = (w_in_use == '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_head <= '0;
         r_cmt  <= '0;
         r_tail <= '0;
      end else begin
         r_head <= w_head_nxt;
         r_cmt  <= w_cmt_nxt;
         r_tail <= w_tail_nxt;
      end
   end

   for (genvar g = 0; g < SQ_DEPTH; g++) begin : g_slot
      localparam logic [IDX_W-1:0] SLOT_IDX = IDX_W'(g);

      logic [IDX_W-1:0] w_rel_head;
      logic [IDX_W-1:0] w_rel_cmt;
      logic             w_sel0;
      logic             w_sel1;
      logic             w_alloc;
      logic             w_capture;
      logic             w_commit;
      logic             w_free;

      assign w_rel_head = SLOT_IDX - w_head_idx;
      assign w_rel_cmt  = SLOT_IDX - w_cmt_idx;
      assign w_sel0     = ~flush & disp_valid[0] & (w_tail_idx == SLOT_IDX);
      assign w_sel1     = ~flush & disp_valid[1] & (w_slot1_idx == SLOT_IDX);
      assign w_alloc    = w_sel0 | w_sel1;
      // Only live entries snoop; committed ones are already ready, so gating
      // on flush only drops captures into entries being squashed.
      assign w_capture  = ({1'b0, w_rel_head} < w_in_use) & ~flush;
      assign w_commit   = ((w_rel_cmt == '0) && (commit_cnt != 2'd0))
                       || ((w_rel_cmt == IDX_W'(1)) && (commit_cnt == 2'd2));
      assign w_free     = w_ack & (w_head_idx == SLOT_IDX);

      sq_slot #(.CDB_NUM(CDB_NUM)) u_slot (
         .clock        (clock),
         .reset_n      (reset_n),
         .i_alloc      (w_alloc),
         .i_base       (w_sel1 ? disp_base[1]       : disp_base[0]),
         .i_base_valid (w_sel1 ? disp_base_valid[1] : disp_base_valid[0]),
         .i_offset     (w_sel1 ? disp_offset[1]     : disp_offset[0]),
         .i_data       (w_sel1 ? disp_data[1]       : disp_data[0]),
         .i_data_valid (w_sel1 ? disp_data_valid[1] : disp_data_valid[0]),
         .i_rob_idx    (w_sel1 ? disp_rob_idx[1]    : disp_rob_idx[0]),
         .i_capture_en (w_capture),
         .i_commit     (w_commit),
         .i_free       (w_free),
         .i_cdb_valid  (cdb_valid),
         .i_cdb_tag    (cdb_tag),
         .i_cdb_data   (cdb_data),
         .o_ready      (w_slot_ready[g]),
         .o_addr       (w_slot_addr[g]),
         .o_data       (w_slot_data[g]),
         .o_rob_idx    (w_slot_rob[g]),
         .o_committed  (w_slot_committed[g])
      );
   end

endmodule
